pipeline_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline: F/D, D/E, E/M, M/W pipeline registers.
- Compares D-stage source operands with E/M destination registers and their forwarded T_new values.
- Tracks the multi-cycle mult/div unit through a busy timer, and sequences exception flushes.
- Drives the en / clr / ReqClr inputs of every pipeline register and the PC enable; also keeps a stall-cycle performance counter.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/md_busy_timer.sv | 60 ++++++
 rtl/pipeline_ctrl.sv | 91 +++++++++
 tb/tb_pipeline_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline control constants, types and helpers
package pipeline_pkg;

   // Width of the T_use / T_new timing fields
   localparam int TW = 3;

   // T_use value meaning "operand not read by this instruction"
   localparam logic [TW-1:0] T_UNUSED = 3'd7;

   // Default md unit latencies in cycles after the issuing edge
   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   // Exception entry point, shared with the pipeline registers' ReqClr path
   localparam logic [31:0] EXC_VECTOR_PC = 32'h0000_4180;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // Timer width wide enough for the longer latency, never below 4 bits
   function automatic int md_timer_width(input int mult_cycles, input int div_cycles);
      int longest;
      int w;
      longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      w = $clog2(longest + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - load/decrement busy timer for the mult/div unit
module md_busy_timer
   import pipeline_pkg::*;
#(
   parameter int MULT_CYCLES = pipeline_pkg::MULT_CYCLES,
   parameter int DIV_CYCLES  = pipeline_pkg::DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_md_start,
   input  logic i_md_is_div,
   input  logic i_flush,
   output logic o_md_busy
);

   localparam int MD_W = md_timer_width(MULT_CYCLES, DIV_CYCLES);

   md_state_e         r_state;
   md_state_e         w_state_nxt;
   logic [MD_W-1:0]   r_timer;
   logic [MD_W-1:0]   w_timer_nxt;

   // State and timer registers; reset clears the timer without waiting for clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MD_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Load on a start that is not being flushed; starts while busy are ignored
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
         MD_IDLE: begin
            if (i_md_start && !i_flush) begin
               w_timer_nxt = i_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
               w_state_nxt = MD_BUSY;
            end
         end
         MD_BUSY: begin
            w_timer_nxt = r_timer - MD_W'(1);
            if (r_timer == MD_W'(1)) begin
               w_state_nxt = MD_IDLE;
            end
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   assign o_md_busy = (r_timer != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler and stall counter for the 5-stage pipeline
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MULT_CYCLES = pipeline_pkg::MULT_CYCLES,
   parameter int DIV_CYCLES  = pipeline_pkg::DIV_CYCLES,
   parameter int TW          = pipeline_pkg::TW,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [TW-1:0]    d_tuse_rs,
   input  logic [TW-1:0]    d_tuse_rt,
   input  logic             d_is_md,
   input  logic [4:0]       e_dst,
   input  logic [TW-1:0]    e_tnew,
   input  logic [4:0]       m_dst,
   input  logic [TW-1:0]    m_tnew,
   input  logic             e_md_start,
   input  logic             e_md_is_div,
   input  logic             exc_req,
   output logic             en_pc,
   output logic             en_fd,
   output logic             clr_de,
   output logic             req_clr,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             w_md_busy;
   logic             w_stall_rs;
   logic             w_stall_rt;
   logic             w_stall_md;
   logic             w_stall;
   logic [CNT_W-1:0] r_stall_cnt;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_timer (
      .clk         (clk),
      .reset       (reset),
      .i_md_start  (e_md_start),
      .i_md_is_div (e_md_is_div),
      .i_flush     (exc_req),
      .o_md_busy   (w_md_busy)
   );

   // Operand hazards: a producer stalls D only when its result arrives later than D needs it
   always_comb begin
      w_stall_rs = (d_rs != 5'd0) &&
                   (((d_rs == e_dst) && (e_tnew > d_tuse_rs)) ||
                    ((d_rs == m_dst) && (m_tnew > d_tuse_rs)));
      w_stall_rt = (d_rt != 5'd0) &&
                   (((d_rt == e_dst) && (e_tnew > d_tuse_rt)) ||
                    ((d_rt == m_dst) && (m_tnew > d_tuse_rt)));
      w_stall_md = d_is_md && (w_md_busy || e_md_start);
      // Held reset forces a clean, non-stalling pipeline
      w_stall    = reset && (w_stall_rs || w_stall_rt || w_stall_md);
   end

   // Pipeline register controls; an exception flush overrides any stall
   always_comb begin
      en_pc   = 1'b1;
      en_fd   = 1'b1;
      clr_de  = 1'b0;
      req_clr = 1'b0;
      if (exc_req) begin
         req_clr = 1'b1;
      end else if (w_stall) begin
         en_pc  = 1'b0;
         en_fd  = 1'b0;
         clr_de = 1'b1;
      end
   end

   // Stall performance counter; flushed cycles are not counted as stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !exc_req) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign md_busy   = w_md_busy;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  d_rs, d_rt, e_dst, m_dst;
   logic [2:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        d_is_md, e_md_start, e_md_is_div, exc_req;
   logic        en_pc, en_fd, clr_de, req_clr, md_busy;
   logic [31:0] stall_cnt;

   int          errors = 0;
   int          checks = 0;

   // Reference model state: cycles of md work remaining and stalls seen
   int          m_remaining;
   logic [31:0] m_cnt;

   pipeline_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .d_rs        (d_rs),
      .d_rt        (d_rt),
      .d_tuse_rs   (d_tuse_rs),
      .d_tuse_rt   (d_tuse_rt),
      .d_is_md     (d_is_md),
      .e_dst       (e_dst),
      .e_tnew      (e_tnew),
      .m_dst       (m_dst),
      .m_tnew      (m_tnew),
      .e_md_start  (e_md_start),
      .e_md_is_div (e_md_is_div),
      .exc_req     (exc_req),
      .en_pc       (en_pc),
      .en_fd       (en_fd),
      .clr_de      (clr_de),
      .req_clr     (req_clr),
      .md_busy     (md_busy),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit operand_waits(input logic [4:0] src, input logic [2:0] tuse);
      bit from_e, from_m;
      from_e = (src == e_dst) && (int'(e_tnew) > int'(tuse));
      from_m = (src == m_dst) && (int'(m_tnew) > int'(tuse));
      return (src != 0) && (from_e || from_m);
   endfunction

   function automatic bit model_stall();
      bit md_wait;
      if (!reset) return 1'b0;
      md_wait = d_is_md && ((m_remaining > 0) || e_md_start);
      return operand_waits(d_rs, d_tuse_rs) || operand_waits(d_rt, d_tuse_rt) || md_wait;
   endfunction

   task automatic check_all();
      bit s;
      s = model_stall();
      check("req_clr", {31'd0, req_clr}, {31'd0, exc_req});
      check("en_pc",   {31'd0, en_pc},   {31'd0, exc_req || !s});
      check("en_fd",   {31'd0, en_fd},   {31'd0, exc_req || !s});
      check("clr_de",  {31'd0, clr_de},  {31'd0, !exc_req && s});
      check("md_busy", {31'd0, md_busy}, {31'd0, m_remaining > 0});
      check("stall_cnt", stall_cnt, m_cnt);
   endtask

   // Check this cycle, clock once, and advance the model across the edge
   task automatic step();
      bit s;
      #1;
      check_all();
      s = model_stall();
      @(posedge clk);
      if (!reset) begin
         m_remaining = 0;
         m_cnt = 0;
      end else begin
         if (s && !exc_req) m_cnt = m_cnt + 1;
         if (m_remaining > 0) m_remaining = m_remaining - 1;
         else if (e_md_start && !exc_req) m_remaining = e_md_is_div ? 10 : 5;
      end
      #1;
   endtask

   task automatic idle_inputs();
      d_rs = 0; d_rt = 0; d_tuse_rs = 7; d_tuse_rt = 7; d_is_md = 0;
      e_dst = 0; e_tnew = 0; m_dst = 0; m_tnew = 0;
      e_md_start = 0; e_md_is_div = 0; exc_req = 0;
   endtask

   initial begin
      logic [31:0] cnt0;
      m_remaining = 0;
      m_cnt = 0;
      reset = 1'b0;
      idle_inputs();

      // Reset held: outputs settle without a clock edge, even with a hazard present
      d_rs = 5; d_tuse_rs = 0; e_dst = 5; e_tnew = 2;
      #1;
      check("rst_en_pc", {31'd0, en_pc}, 32'd1);
      check("rst_clr_de", {31'd0, clr_de}, 32'd0);
      check("rst_md_busy", {31'd0, md_busy}, 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      exc_req = 1;
      #1;
      check("rst_req_clr", {31'd0, req_clr}, 32'd1);
      exc_req = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_inputs();
      step();

      // Load-use: stalled on E, then on M, then released
      cnt0 = m_cnt;
      d_rs = 5; d_tuse_rs = 0; e_dst = 5; e_tnew = 2;
      #1;
      check("lu_en_pc", {31'd0, en_pc}, 32'd0);
      check("lu_clr_de", {31'd0, clr_de}, 32'd1);
      step();
      e_tnew = 0; m_dst = 5; m_tnew = 1;
      step();
      m_tnew = 0;
      step();
      check("lu_cnt_delta", stall_cnt - cnt0, 32'd2);

      // $0 never stalls; forwardable producer does not stall
      idle_inputs();
      d_rs = 0; e_dst = 0; e_tnew = 2; d_tuse_rs = 0;
      step();
      idle_inputs();
      d_rt = 8; d_tuse_rt = 1; e_dst = 8; e_tnew = 1;
      #1;
      check("fwd_en_pc", {31'd0, en_pc}, 32'd1);
      step();

      // Mult followed by an md-dependent instruction
      idle_inputs();
      e_md_start = 1; e_md_is_div = 0; d_is_md = 1;
      step();
      e_md_start = 0;
      for (int i = 0; i < 6; i++) step();
      check("mult_released_en_pc", {31'd0, en_pc}, 32'd1);

      // Div with an exception arriving mid-run
      idle_inputs();
      e_md_start = 1; e_md_is_div = 1;
      step();
      idle_inputs();
      for (int i = 1; i <= 11; i++) begin
         exc_req = (i == 3);
         d_is_md = (i == 3);
         step();
      end
      check("div_done_busy", {31'd0, md_busy}, 32'd0);

      // Exception beats both a hazard stall and an md start
      idle_inputs();
      cnt0 = m_cnt;
      d_rs = 3; d_tuse_rs = 0; e_dst = 3; e_tnew = 2;
      exc_req = 1; e_md_start = 1;
      step();
      exc_req = 0; e_md_start = 0; d_rs = 0;
      step();
      check("exc_cnt_same", stall_cnt, cnt0);
      check("exc_no_busy", {31'd0, md_busy}, 32'd0);

      // Randomized traffic with small register space to force collisions
      for (int n = 0; n < 400; n++) begin
         d_rs = 5'($urandom_range(0, 3));
         d_rt = 5'($urandom_range(0, 3));
         d_tuse_rs = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
         d_tuse_rt = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
         e_dst = 5'($urandom_range(0, 3));
         m_dst = 5'($urandom_range(0, 3));
         e_tnew = 3'($urandom_range(0, 2));
         m_tnew = 3'($urandom_range(0, 1));
         d_is_md = ($urandom_range(0, 3) == 0);
         e_md_start = ($urandom_range(0, 9) == 0);
         e_md_is_div = $urandom_range(0, 1) == 1;
         exc_req = ($urandom_range(0, 19) == 0);
         step();
      end

      // Asynchronous reset in the middle of a divide
      idle_inputs();
      step();
      while (m_remaining > 0) step();
      d_rs = 2; d_tuse_rs = 0; e_dst = 2; e_tnew = 2;
      step();
      idle_inputs();
      e_md_start = 1; e_md_is_div = 1;
      step();
      e_md_start = 0;
      for (int i = 0; i < 3; i++) step();
      #2;
      reset = 1'b0;
      #1;
      check("arst_md_busy", {31'd0, md_busy}, 32'd0);
      check("arst_stall_cnt", stall_cnt, 32'd0);
      m_remaining = 0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("arst_idle_en_pc", {31'd0, en_pc}, 32'd1);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
